text_console: RTL and testbench

//  Character-stream front end for the 80x25 text video mode. Accepts bytes from the CPU port.

---
 rtl/video_pkg.sv | 26 ++
 rtl/text_fill_seq.sv | 41 ++++
 rtl/text_console.sv | 194 +++++++++++++++++++
 tb/tb_text_console.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared constants and state encoding for the text-mode video blocks.
package video_pkg;

  localparam int TEXT_COLS       = 80;
  localparam int TEXT_ROWS       = 25;
  localparam int TEXT_CELL_BYTES = 2;

  localparam logic [12:0] PALETTE_BASE = 13'hFA0;
  localparam logic [12:0] FONT_BASE    = 13'h1000;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    PUT_CH,
    PUT_AT,
    SCR_RD,
    SCR_WR,
    FILL,
    CLR
  } tc_state_t;

endpackage

// File: rtl/text_fill_seq.sv
// Byte sequencer for block fills: walks start..start+length-1, char on even bytes, attr on odd.
module text_fill_seq #(
  parameter logic [7:0]  FILL_CHAR = 8'h20,
  parameter logic [12:0] RESET_LEN = 13'd4000
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        start,
  input  logic        advance,
  input  logic [12:0] start_addr,
  input  logic [12:0] length,
  input  logic [7:0]  fill_attr,
  output logic [12:0] addr,
  output logic [7:0]  data,
  output logic        last
);

  logic [12:0] base;
  logic [12:0] count;
  logic [12:0] len;

  // Reset preloads a full-screen run so a clear can start without a load cycle.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      base  <= '0;
      count <= '0;
      len   <= RESET_LEN;
    end else if (start) begin
      base  <= start_addr;
      count <= '0;
      len   <= length;
    end else if (advance) begin
      count <= count + 13'd1;
    end
  end

  assign addr = base + count;
  assign data = addr[0] ? fill_attr : FILL_CHAR;
  assign last = (count == len - 13'd1);

endmodule

// File: rtl/text_console.sv
// Character-stream front end for 80x25 text mode: prints bytes, handles CR/LF/BS/FF, scrolls.
module text_console
  import video_pkg::*;
#(
  parameter int         COLS           = TEXT_COLS,
  parameter int         ROWS           = TEXT_ROWS,
  parameter logic [7:0] FILL_CHAR      = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  input  logic [7:0]  in_attr,
  output logic        busy,
  output logic [7:0]  cursor_x,
  output logic [7:0]  cursor_y,
  output logic [12:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  localparam logic [12:0] ROW_BYTES    = 13'(TEXT_CELL_BYTES * COLS);
  localparam logic [12:0] SCROLL_BYTES = 13'(TEXT_CELL_BYTES * COLS * (ROWS - 1));
  localparam logic [12:0] SCREEN_BYTES = 13'(TEXT_CELL_BYTES * COLS * ROWS);
  localparam logic [12:0] COLS_W       = 13'(COLS);
  localparam logic [7:0]  X_MAX        = 8'(COLS - 1);
  localparam logic [7:0]  Y_MAX        = 8'(ROWS - 1);

  tc_state_t   state, state_n;
  logic [7:0]  cur_x, cur_x_n, cur_y, cur_y_n;
  logic [7:0]  char_q, char_n, attr_q, attr_n;
  logic [12:0] scr_i, scr_i_n;
  logic [12:0] cell_addr;
  logic        accept;

  logic        fill_start, fill_adv, fill_last;
  logic [12:0] fill_base, fill_len, fill_addr;
  logic [7:0]  fill_data;

  text_fill_seq #(
    .FILL_CHAR (FILL_CHAR),
    .RESET_LEN (SCREEN_BYTES)
  ) u_fill (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .start      (fill_start),
    .advance    (fill_adv),
    .start_addr (fill_base),
    .length     (fill_len),
    .fill_attr  (attr_q),
    .addr       (fill_addr),
    .data       (fill_data),
    .last       (fill_last)
  );

  assign accept    = in_valid & in_ready;
  assign cell_addr = 13'(TEXT_CELL_BYTES) * ({5'd0, cur_x} + COLS_W * {5'd0, cur_y});
  assign cursor_x  = cur_x;
  assign cursor_y  = cur_y;
  assign busy      = ~in_ready;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= CLEAR_ON_RESET ? CLR : IDLE;
      cur_x  <= '0;
      cur_y  <= '0;
      char_q <= '0;
      attr_q <= 8'h07;
      scr_i  <= '0;
    end else begin
      state  <= state_n;
      cur_x  <= cur_x_n;
      cur_y  <= cur_y_n;
      char_q <= char_n;
      attr_q <= attr_n;
      scr_i  <= scr_i_n;
    end
  end

  always_comb begin
    state_n    = state;
    cur_x_n    = cur_x;
    cur_y_n    = cur_y;
    char_n     = char_q;
    attr_n     = attr_q;
    scr_i_n    = scr_i;
    fill_start = 1'b0;
    fill_base  = '0;
    fill_len   = SCREEN_BYTES;
    case (state)
      IDLE: if (accept) begin
        attr_n = in_attr;
        case (in_char)
          CC_CR: cur_x_n = '0;
          CC_LF: begin
            cur_x_n = '0;
            if (cur_y < Y_MAX) cur_y_n = cur_y + 8'd1;
            else begin
              state_n = SCR_RD;
              scr_i_n = '0;
            end
          end
          CC_BS: begin
            if (cur_x != '0) cur_x_n = cur_x - 8'd1;
            else if (cur_y != '0) begin
              cur_x_n = X_MAX;
              cur_y_n = cur_y - 8'd1;
            end
          end
          CC_FF: begin
            state_n    = CLR;
            fill_start = 1'b1;
          end
          default: begin
            char_n  = in_char;
            state_n = PUT_CH;
          end
        endcase
      end
      PUT_CH: state_n = PUT_AT;
      PUT_AT: begin
        state_n = IDLE;
        if (cur_x < X_MAX) cur_x_n = cur_x + 8'd1;
        else begin
          cur_x_n = '0;
          if (cur_y < Y_MAX) cur_y_n = cur_y + 8'd1;
          else begin
            state_n = SCR_RD;
            scr_i_n = '0;
          end
        end
      end
      SCR_RD: state_n = SCR_WR;
      SCR_WR: begin
        if (scr_i == SCROLL_BYTES - 13'd1) begin
          state_n    = FILL;
          fill_start = 1'b1;
          fill_base  = SCROLL_BYTES;
          fill_len   = ROW_BYTES;
        end else begin
          scr_i_n = scr_i + 13'd1;
          state_n = SCR_RD;
        end
      end
      FILL: if (fill_last) state_n = IDLE;
      CLR: if (fill_last) begin
        state_n = IDLE;
        cur_x_n = '0;
        cur_y_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, since the reset state may be CLR.
  always_comb begin
    mem_we      = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    fill_adv    = 1'b0;
    in_ready    = RESET_N && (state == IDLE);
    if (RESET_N) begin
      case (state)
        PUT_CH: begin
          mem_we      = 1'b1;
          mem_address = cell_addr;
          mem_wdata   = char_q;
        end
        PUT_AT: begin
          mem_we      = 1'b1;
          mem_address = cell_addr + 13'd1;
          mem_wdata   = attr_q;
        end
        SCR_RD: mem_address = scr_i + ROW_BYTES;
        SCR_WR: begin
          mem_we      = 1'b1;
          mem_address = scr_i;
          mem_wdata   = mem_rdata;
        end
        FILL, CLR: begin
          mem_we      = 1'b1;
          mem_address = fill_addr;
          mem_wdata   = fill_data;
          fill_adv    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: vector table, hand sequences, random stream vs screen model.
module tb_text_console;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_char = 8'h00;
  logic [7:0]  in_attr = 8'h00;
  logic        busy;
  logic [7:0]  cursor_x, cursor_y;
  logic [12:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  int tests = 0;
  int failed = 0;
  int bad_wr = 0;

  logic [7:0] mem  [0:8191];
  logic [7:0] snap [0:3999];

  logic [7:0] m_ch [0:24][0:79];
  logic [7:0] m_at [0:24][0:79];
  int         mx, my;
  logic [7:0] m_attr;

  typedef struct {
    logic [7:0] c;
    logic [7:0] a;
    int         ex;
    int         ey;
    int         elat;
  } vec_t;

  text_console dut (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_char     (in_char),
    .in_attr     (in_attr),
    .busy        (busy),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
  );

  always #5 CLOCK = ~CLOCK;

  // Registered-read text RAM, port B side.
  always @(posedge CLOCK) begin
    if (mem_we) mem[mem_address] <= mem_wdata;
    mem_rdata <= mem[mem_address];
    if (RESET_N && mem_we && mem_address >= 13'd4000) bad_wr++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic m_fill_row(input int r);
    for (int c = 0; c < 80; c++) begin
      m_ch[r][c] = 8'h20;
      m_at[r][c] = m_attr;
    end
  endtask

  task automatic m_clear();
    for (int r = 0; r < 25; r++) m_fill_row(r);
  endtask

  task automatic m_reset();
    m_attr = 8'h07;
    m_clear();
    mx = 0;
    my = 0;
  endtask

  task automatic m_newline(output int extra);
    extra = 0;
    if (my < 24) my++;
    else begin
      for (int r = 0; r < 24; r++)
        for (int c = 0; c < 80; c++) begin
          m_ch[r][c] = m_ch[r+1][c];
          m_at[r][c] = m_at[r+1][c];
        end
      m_fill_row(24);
      extra = 2 * 3840 + 160;
    end
  endtask

  // Returns cycles from the accepting edge until in_ready is seen high again.
  task automatic model_apply(input logic [7:0] c, input logic [7:0] a, output int lat);
    int e;
    e = 0;
    m_attr = a;
    case (c)
      8'h0D: begin mx = 0; lat = 1; end
      8'h0A: begin mx = 0; m_newline(e); lat = 1 + e; end
      8'h08: begin
        if (mx > 0) mx--;
        else if (my > 0) begin mx = 79; my--; end
        lat = 1;
      end
      8'h0C: begin m_clear(); mx = 0; my = 0; lat = 4001; end
      default: begin
        m_ch[my][mx] = c;
        m_at[my][mx] = a;
        lat = 3;
        if (mx < 79) mx++;
        else begin mx = 0; m_newline(e); lat = 3 + e; end
      end
    endcase
  endtask

  task automatic check_screen(input string name);
    int bad, a;
    bad = 0;
    for (int y = 0; y < 25; y++)
      for (int x = 0; x < 80; x++) begin
        a = 2 * (x + 80 * y);
        if (mem[a] !== m_ch[y][x] || mem[a+1] !== m_at[y][x]) bad++;
      end
    check(name, bad, 0);
  endtask

  task automatic check_cursor(input string name);
    check({name, "_x"}, cursor_x, mx);
    check({name, "_y"}, cursor_y, my);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 20000) begin
      @(negedge CLOCK);
      n++;
    end
  endtask

  task automatic send_byte(input logic [7:0] c, input logic [7:0] a, output int lat, output int mlat);
    int n;
    wait_ready(n);
    check("ready_before_send", in_ready, 1);
    in_valid = 1'b1;
    in_char  = c;
    in_attr  = a;
    @(negedge CLOCK);
    in_valid = 1'b0;
    model_apply(c, a, mlat);
    lat = 1;
    while (!in_ready && lat < 20000) begin
      @(negedge CLOCK);
      lat++;
    end
  endtask

  task automatic send_chk(input logic [7:0] c, input logic [7:0] a, input string name);
    int lat, mlat;
    send_byte(c, a, lat, mlat);
    check(name, lat, mlat);
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    logic [7:0] c;
    r = $urandom_range(0, 99);
    if (r < 4) return 8'h0A;
    if (r < 8) return 8'h0D;
    if (r < 12) return 8'h08;
    c = 8'($urandom);
    while (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D) c = 8'($urandom);
    return c;
  endfunction

  // Source asserts valid at random and holds each byte until it is taken.
  task automatic run_stream(input int nbytes);
    int sent, cyc, lat;
    bit took;
    sent = 0;
    cyc  = 0;
    while (sent < nbytes && cyc < 60000) begin
      if (!in_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_char  = rand_char();
          in_attr  = 8'($urandom);
        end else in_char = 8'($urandom);
      end
      took = in_valid && in_ready;
      if (took) begin
        model_apply(in_char, in_attr, lat);
        sent++;
      end
      @(negedge CLOCK);
      cyc++;
      if (took) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("stream_bytes", sent, nbytes);
    wait_ready(lat);
    check("stream_ready", in_ready, 1);
    check_screen("stream_screen");
    check_cursor("stream_cursor");
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [12];
    int n, lat, mlat, bad;

    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);

    tbl[0]  = '{8'h41, 8'h1E, 1,  0, 3};
    tbl[1]  = '{8'h42, 8'h2F, 2,  0, 3};
    tbl[2]  = '{8'h08, 8'h07, 1,  0, 1};
    tbl[3]  = '{8'h0D, 8'h07, 0,  0, 1};
    tbl[4]  = '{8'h08, 8'h07, 0,  0, 1};
    tbl[5]  = '{8'h0A, 8'h07, 0,  1, 1};
    tbl[6]  = '{8'h0A, 8'h07, 0,  2, 1};
    tbl[7]  = '{8'h0A, 8'h07, 0,  3, 1};
    tbl[8]  = '{8'h0A, 8'h07, 0,  4, 1};
    tbl[9]  = '{8'h0A, 8'h07, 0,  5, 1};
    tbl[10] = '{8'h08, 8'h07, 79, 4, 1};
    tbl[11] = '{8'h5A, 8'h4C, 0,  5, 3};

    // Reset values while held, then the power-on clear.
    #12;
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_address, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_cx", cursor_x, 0);
    check("rst_cy", cursor_y, 0);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    m_reset();
    wait_ready(n);
    check("clr_cycles", n, 4000);
    check_screen("clr_screen");
    check_cursor("clr_cursor");

    for (int i = 0; i < 12; i++) begin
      send_byte(tbl[i].c, tbl[i].a, lat, mlat);
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].elat);
      check($sformatf("tbl%0d_x", i), cursor_x, tbl[i].ex);
      check($sformatf("tbl%0d_y", i), cursor_y, tbl[i].ey);
      if (i == 0) begin
        check("A_char", mem[0], 8'h41);
        check("A_attr", mem[1], 8'h1E);
      end
    end
    check_screen("tbl_screen");

    send_byte(8'h0C, 8'h17, lat, mlat);
    check("ff_lat", lat, 4001);
    check_screen("ff_screen");
    check_cursor("ff_cursor");

    for (int i = 0; i < 3; i++) send_chk(8'h0A, 8'h17, "lf_lat");
    for (int i = 0; i < 80; i++) send_chk(8'(8'h41 + i % 26), 8'h2A, "row_lat");
    check("row_cx", cursor_x, 0);
    check("row_cy", cursor_y, 4);
    check("row_last_char", mem[638], 8'h42);
    check("row_last_attr", mem[639], 8'h2A);

    for (int i = 0; i < 5; i++) send_chk(8'h0A, 8'h17, "lf_lat");
    for (int i = 0; i < 37; i++) send_chk(8'(8'h61 + i % 26), 8'h71, "pr_lat");
    check("cr_pre_x", cursor_x, 37);
    check("cr_pre_y", cursor_y, 9);
    send_byte(8'h0D, 8'h17, lat, mlat);
    check("cr_lat", lat, 1);
    check("cr_x", cursor_x, 0);
    check("cr_y", cursor_y, 9);
    check_screen("cr_screen");

    for (int i = 0; i < 15; i++) send_chk(8'h0A, 8'h17, "lf_lat");
    check("scr_pre_y", cursor_y, 24);
    for (int i = 0; i < 4000; i++) snap[i] = mem[i];
    send_byte(8'h0A, 8'h3C, lat, mlat);
    check("scroll_lat", lat, 2 * 3840 + 160 + 1);
    bad = 0;
    for (int i = 0; i < 3840; i++) if (mem[i] !== snap[i+160]) bad++;
    check("scroll_moved", bad, 0);
    bad = 0;
    for (int i = 3840; i < 4000; i += 2) if (mem[i] !== 8'h20 || mem[i+1] !== 8'h3C) bad++;
    check("scroll_fill", bad, 0);
    check("scroll_cx", cursor_x, 0);
    check("scroll_cy", cursor_y, 24);
    check_screen("scroll_screen");

    // Reset in the middle of a scroll.
    in_valid = 1'b1;
    in_char  = 8'h0A;
    in_attr  = 8'h5B;
    @(negedge CLOCK);
    in_valid = 1'b0;
    repeat (1500) @(negedge CLOCK);
    #2 RESET_N = 1'b0;
    #1;
    check("abort_we", mem_we, 0);
    check("abort_addr", mem_address, 0);
    check("abort_wdata", mem_wdata, 0);
    check("abort_cx", cursor_x, 0);
    check("abort_cy", cursor_y, 0);
    check("abort_ready", in_ready, 0);
    repeat (2) @(negedge CLOCK);
    RESET_N = 1'b1;
    m_reset();
    wait_ready(n);
    check("abort_clr_cycles", n, 4000);
    check_screen("abort_screen");
    check_cursor("abort_cursor");

    for (int i = 0; i < 18; i++) send_chk(8'h0A, 8'h07, "lf_lat");
    run_stream(160);

    check("illegal_writes", bad_wr, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
